// File: rtl/aer_event_packetizer.sv
// AER event packetizer: timestamps arbiter grants, buffers them in a FWFT FIFO
// and streams {type,pol,x,y,ts} packets plus timestamp-wrap markers.
module aer_event_packetizer #(
   parameter int X_W      = 1,
   parameter int Y_W      = 1,
   parameter int TS_W     = 16,
   parameter int TICK_DIV = 1,
   parameter int DEPTH    = 8
) (
   input  logic                         clk_i,
   input  logic                         reset_ni,
   input  logic                         enable_i,
   input  logic                         evt_valid_i,
   input  logic [X_W-1:0]               x_add_i,
   input  logic [Y_W-1:0]               y_add_i,
   input  logic                         pol_i,
   input  logic                         evt_ready_i,
   output logic                         evt_valid_o,
   output logic [2+X_W+Y_W+TS_W-1:0]    evt_data_o,
   output logic                         stall_o,
   output logic                         full_o,
   output logic [7:0]                   drop_cnt_o
);

   localparam int PKT_W = 2 + X_W + Y_W + TS_W;
   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = AW + 1;
   localparam int DW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [TS_W-1:0]  ts_q;
   logic [TS_W-1:0]  wrap_cnt_q;
   logic             wrap_pend_q;
   logic [DW-1:0]    div_q;
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    cnt_q;
   logic [7:0]       drop_q;
   logic [PKT_W-1:0] mem_q [DEPTH];

   logic             tick;
   logic             wrap;
   logic             full;
   logic             not_empty;
   logic             ev_wr;
   logic             mk_wr;
   logic             wr_en;
   logic             pop;
   logic             drop;
   logic [PKT_W-1:0] wr_data;
   logic [CW-1:0]    cnt_nxt;

   always_comb begin
      tick      = 1'b0;
      wrap      = 1'b0;
      full      = (cnt_q == CW'(DEPTH));
      not_empty = (cnt_q != '0);
      ev_wr     = 1'b0;
      mk_wr     = 1'b0;
      drop      = 1'b0;
      wr_data   = '0;
      if (enable_i) begin
         tick  = (div_q == DW'(TICK_DIV - 1));
         wrap  = tick && (ts_q == {TS_W{1'b1}});
         ev_wr = evt_valid_i && !full;
         drop  = evt_valid_i && full;
         // a pending marker only takes slots that no event wants
         mk_wr = wrap_pend_q && !full && !ev_wr;
      end
      wr_en = ev_wr || mk_wr;
      if (ev_wr)
         wr_data = {1'b0, pol_i, x_add_i, y_add_i, ts_q};
      else if (mk_wr)
         wr_data = {1'b1, 1'b0, {X_W{1'b0}}, {Y_W{1'b0}}, wrap_cnt_q};
      pop     = not_empty && evt_ready_i;
      cnt_nxt = cnt_q + CW'(wr_en) - CW'(pop);
   end

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         ts_q        <= '0;
         div_q       <= '0;
         wrap_cnt_q  <= '0;
         wrap_pend_q <= 1'b0;
      end else if (enable_i) begin
         div_q <= tick ? '0 : div_q + DW'(1);
         if (tick)
            ts_q <= ts_q + TS_W'(1);
         if (wrap)
            wrap_cnt_q <= wrap_cnt_q + TS_W'(1);
         // a new wrap re-arms the marker even if one leaves this cycle
         wrap_pend_q <= wrap || (wrap_pend_q && !mk_wr);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         drop_q   <= '0;
      end else begin
         if (wr_en)
            wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)
            rd_ptr_q <= rd_ptr_q + AW'(1);
         cnt_q <= cnt_nxt;
         if (drop && drop_q != 8'hFF)
            drop_q <= drop_q + 8'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_ni && wr_en)
         mem_q[wr_ptr_q] <= wr_data;
   end

   always_comb begin
      evt_valid_o = not_empty;
      evt_data_o  = not_empty ? mem_q[rd_ptr_q] : '0;
      stall_o     = (cnt_q >= CW'(DEPTH - 1));
      full_o      = full;
      drop_cnt_o  = drop_q;
   end

endmodule
